// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared vending money types, coin encodings and helpers
package vm_pkg;

    localparam int          MONEY_W   = 11;
    localparam logic [10:0] MONEY_MAX = 11'd2047;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        RETURN   = 2'd3
    } vm_state_t;

    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_5  = 2'b01,
        COIN_10 = 2'b10,
        COIN_25 = 2'b11
    } coin_type_t;

    localparam logic [10:0] COIN_1_VAL  = 11'd1;
    localparam logic [10:0] COIN_5_VAL  = 11'd5;
    localparam logic [10:0] COIN_10_VAL = 11'd10;
    localparam logic [10:0] COIN_25_VAL = 11'd25;

    // Money totals clamp at MONEY_MAX instead of wrapping.
    function automatic logic [10:0] sat_add(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sat_add = (sum > {1'b0, MONEY_MAX}) ? MONEY_MAX : sum[10:0];
    endfunction

endpackage

// File: rtl/coin_value_decode.sv
// rtl/coin_value_decode.sv - combinational coin_type to base-unit value
module coin_value_decode
    import vm_pkg::*;
(
    input  logic [1:0]  coin_type,
    output logic [10:0] value
);

    always_comb begin
        value = COIN_1_VAL;
        case (coin_type)
            COIN_1:  value = COIN_1_VAL;
            COIN_5:  value = COIN_5_VAL;
            COIN_10: value = COIN_10_VAL;
            COIN_25: value = COIN_25_VAL;
            default: value = COIN_1_VAL;
        endcase
    end

endmodule

// File: rtl/coin_bank.sv
// rtl/coin_bank.sv - coin acceptance, credit, pricing and change; REFUND_TIMEOUT_EN adds idle auto-refund
module coin_bank
    import vm_pkg::*;
#(
    parameter logic [10:0] PRICE0  = 11'd15,
    parameter logic [10:0] PRICE1  = 11'd25,
    parameter logic [10:0] PRICE2  = 11'd40,
    parameter logic [10:0] PRICE3  = 11'd65,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic [1:0]  item_sel,
    input  logic        buy,
    input  logic        cancel,
    input  logic        owner_take,
    output logic [10:0] machine_money,
    output logic [10:0] credit,
    output logic        dispense,
    output logic [1:0]  item_out,
    output logic        change_valid,
    output logic [10:0] change_amount,
    output logic        coin_reject,
    output logic        low_credit
);

    vm_state_t   state;
    logic [10:0] coin_val;
    logic [10:0] price;
    logic [11:0] credit_sum;
    logic        coin_fits;
    logic        credit_ok;
    logic        timeout_hit;

    coin_value_decode u_decode (
        .coin_type (coin_type),
        .value     (coin_val)
    );

    always_comb begin
        price = PRICE0;
        case (item_sel)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            2'd3:    price = PRICE3;
            default: price = PRICE0;
        endcase
    end

    assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
    assign coin_fits  = (credit_sum <= {1'b0, MONEY_MAX});
    assign credit_ok  = (credit >= price);

`ifdef REFUND_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign timeout_hit = (state == COLLECT) && (idle_cnt == TIMEOUT - 16'd1);

    // Any customer activity, or leaving COLLECT, restarts the idle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= 16'd0;
        end else if (state != COLLECT || mode || timeout_hit ||
                     coin_valid || buy || cancel) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            machine_money <= 11'd0;
            credit        <= 11'd0;
            dispense      <= 1'b0;
            item_out      <= 2'd0;
            change_valid  <= 1'b0;
            change_amount <= 11'd0;
            coin_reject   <= 1'b0;
            low_credit    <= 1'b0;
        end else begin
            dispense      <= 1'b0;
            item_out      <= 2'd0;
            change_valid  <= 1'b0;
            change_amount <= 11'd0;
            coin_reject   <= 1'b0;
            low_credit    <= 1'b0;
            case (state)
                IDLE: begin
                    if (coin_valid) begin
                        if (!mode && coin_fits) begin
                            credit <= credit_sum[10:0];
                            state  <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    if (mode && owner_take)
                        machine_money <= 11'd0;
                end
                COLLECT: begin
                    if (mode || cancel || timeout_hit) begin
                        state         <= RETURN;
                        change_valid  <= (credit != 11'd0);
                        change_amount <= credit;
                        credit        <= 11'd0;
                        coin_reject   <= coin_valid;
                    end else if (buy) begin
                        coin_reject <= coin_valid;
                        if (credit_ok) begin
                            state         <= DISPENSE;
                            dispense      <= 1'b1;
                            item_out      <= item_sel;
                            machine_money <= sat_add(machine_money, price);
                            credit        <= credit - price;
                        end else begin
                            low_credit <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_fits)
                            credit <= credit_sum[10:0];
                        else
                            coin_reject <= 1'b1;
                    end
                end
                DISPENSE: begin
                    state         <= RETURN;
                    change_valid  <= (credit != 11'd0);
                    change_amount <= credit;
                    credit        <= 11'd0;
                    coin_reject   <= coin_valid;
                end
                RETURN: begin
                    state       <= IDLE;
                    coin_reject <= coin_valid;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_bank.sv
// tb/tb_coin_bank.sv - scoreboard bench for coin_bank
module tb_coin_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic [1:0]  item_sel;
    logic        buy;
    logic        cancel;
    logic        owner_take;
    logic [10:0] machine_money;
    logic [10:0] credit;
    logic        dispense;
    logic [1:0]  item_out;
    logic        change_valid;
    logic [10:0] change_amount;
    logic        coin_reject;
    logic        low_credit;

    int n_checks = 0;
    int n_fail   = 0;
    int mm_e     = 0;

    typedef struct {
        logic        disp;
        logic [1:0]  item;
        logic        chg;
        logic [10:0] amt;
        logic        rej;
        logic        low;
        logic [10:0] cr;
        logic [10:0] mm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    coin_bank #(.TIMEOUT(16'd8)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .item_sel      (item_sel),
        .buy           (buy),
        .cancel        (cancel),
        .owner_take    (owner_take),
        .machine_money (machine_money),
        .credit        (credit),
        .dispense      (dispense),
        .item_out      (item_out),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .coin_reject   (coin_reject),
        .low_credit    (low_credit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic disp, input logic [1:0] item, input logic chg,
                              input int amt, input logic rej, input logic low, input int cr);
        exp_t e;
        e.disp = disp; e.item = item; e.chg = chg; e.amt = 11'(amt);
        e.rej = rej; e.low = low; e.cr = 11'(cr); e.mm = 11'(mm_e);
        sb.push_back(e);
    endtask

    // Called just after a rising edge; the strobes are sampled at the next one.
    task automatic step(input logic cv, input logic [1:0] ct, input logic b,
                        input logic [1:0] is, input logic c, input logic ot);
        coin_valid = cv; coin_type = ct; buy = b; item_sel = is; cancel = c; owner_take = ot;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0; owner_take = 1'b0;
    endtask

    task automatic coin(input logic [1:0] ct);
        step(1'b1, ct, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && (dispense || change_valid || coin_reject || low_credit)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got disp=%0b chg=%0b rej=%0b low=%0b, expected none at %0t",
                         dispense, change_valid, coin_reject, low_credit, $time);
            end else begin
                mon_e = sb.pop_front();
                check("dispense", int'(dispense), int'(mon_e.disp));
                if (mon_e.disp) check("item_out", int'(item_out), int'(mon_e.item));
                check("change_valid", int'(change_valid), int'(mon_e.chg));
                check("change_amount", int'(change_amount), int'(mon_e.amt));
                check("coin_reject", int'(coin_reject), int'(mon_e.rej));
                check("low_credit", int'(low_credit), int'(mon_e.low));
                check("credit", int'(credit), int'(mon_e.cr));
                check("machine_money", int'(machine_money), int'(mon_e.mm));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; coin_valid = 1'b0; coin_type = 2'd0;
        item_sel = 2'd0; buy = 1'b0; cancel = 1'b0; owner_take = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_credit", int'(credit), 0);
        check("reset_mm", int'(machine_money), 0);
        check("reset_pulses", int'({dispense, change_valid, coin_reject, low_credit}), 0);
        check("reset_change_amount", int'(change_amount), 0);
        rst = 1'b0;

        // 25+10+5, buy the 40-unit item, nothing left to return
        coin(2'd3); coin(2'd2); coin(2'd1);
        check("credit_40", int'(credit), 40);
        mm_e = 40;
        expect_out(1'b1, 2'd2, 1'b0, 0, 1'b0, 1'b0, 0);
        step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        idle();
        check("exact_change_valid", int'(change_valid), 0);
        check("exact_credit", int'(credit), 0);
        idle();

        // 50 credit, buy item 0, coin during DISPENSE is rejected
        coin(2'd3); coin(2'd3);
        mm_e = 55;
        expect_out(1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0, 35);
        step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        expect_out(1'b0, 2'd0, 1'b1, 35, 1'b1, 1'b0, 0);
        coin(2'd3);
        idle();

        // low credit then cancel
        coin(2'd2);
        expect_out(1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b1, 10);
        step(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        expect_out(1'b0, 2'd0, 1'b1, 10, 1'b0, 1'b0, 0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle();

        // credit ceiling, then coin together with buy
        for (int i = 0; i < 81; i++) coin(2'd3);
        coin(2'd2); coin(2'd1);
        check("credit_2040", int'(credit), 2040);
        expect_out(1'b0, 2'd0, 1'b0, 0, 1'b1, 1'b0, 2040);
        coin(2'd3);
        mm_e = 120;
        expect_out(1'b1, 2'd3, 1'b0, 0, 1'b1, 1'b0, 1975);
        step(1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 1'b0);
        expect_out(1'b0, 2'd0, 1'b1, 1975, 1'b0, 1'b0, 0);
        idle();
        idle();

        // owner mode: coin rejected, withdrawal, forced refund
        mode = 1'b1;
        expect_out(1'b0, 2'd0, 1'b0, 0, 1'b1, 1'b0, 0);
        coin(2'd3);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        mm_e = 0;
        check("owner_take_mm", int'(machine_money), 0);
        mode = 1'b0;
        coin(2'd3); coin(2'd1);
        mode = 1'b1;
        expect_out(1'b0, 2'd0, 1'b1, 30, 1'b0, 1'b0, 0);
        idle();
        idle();
        mode = 1'b0;

        // machine_money saturates at 2047
        for (int k = 0; k < 32; k++) begin
            coin(2'd3); coin(2'd3); coin(2'd3);
            mm_e = (mm_e + 65 > 2047) ? 2047 : mm_e + 65;
            expect_out(1'b1, 2'd3, 1'b0, 0, 1'b0, 1'b0, 10);
            step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
            expect_out(1'b0, 2'd0, 1'b1, 10, 1'b0, 1'b0, 0);
            idle();
            idle();
        end
        check("mm_saturated", int'(machine_money), 2047);

        // idle credit: auto-refund when enabled, otherwise held until cancel
        coin(2'd1);
        repeat (7) idle();
        check("credit_held_7", int'(credit), 5);
`ifdef REFUND_TIMEOUT_EN
        expect_out(1'b0, 2'd0, 1'b1, 5, 1'b0, 1'b0, 0);
        idle();
        idle();
`else
        repeat (20) idle();
        check("credit_held_27", int'(credit), 5);
        expect_out(1'b0, 2'd0, 1'b1, 5, 1'b0, 1'b0, 0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle();
`endif

        // asynchronous reset mid-COLLECT discards credit silently
        coin(2'd3);
        check("credit_before_rst", int'(credit), 25);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_credit", int'(credit), 0);
        check("async_rst_mm", int'(machine_money), 0);
        check("async_rst_pulses", int'({dispense, change_valid, coin_reject, low_credit}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mm_e = 0;
        repeat (4) idle();
        check("post_rst_credit", int'(credit), 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
